// File: rtl/xdma_write_resp_tracker_pkg.sv
// Shared xdma definitions: tracker FSM encoding and AXI write-response codes.
package xdma_write_resp_tracker_pkg;

  // Tracker FSM encoding, kept as plain constants so older tools can share it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_RETIRE = 2'd2;

  // AXI B-channel response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A response marks the request as failed for SLVERR or DECERR.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/xdma_write_resp_tracker_fifo.sv
// Small synchronous FIFO holding the pending per-request burst counts.
// A push and a pop in the same cycle both take effect, even when full.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_DEPTH:0] usage_o,
  input  dtype              data_i,
  input  logic              push_i,
  output dtype              data_o,
  input  logic              pop_i
);

  logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
  logic                  write_en;
  logic                  bypass;
  dtype                  mem_q [DEPTH];

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] p);
    return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = cnt_q;
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
  assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_ptr_q];

  // Next-state for pointers and fill level; a full FIFO accepts a push only alongside a pop.
  always_comb begin
    write_en = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (!bypass) begin
      if (push_i && (!full_o || pop_i)) begin
        write_en = 1'b1;
        wr_ptr_d = next_ptr(wr_ptr_q);
        cnt_d    = cnt_d + 1'b1;
      end
      if (pop_i && (cnt_q != '0)) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
        cnt_d    = cnt_d - 1'b1;
      end
    end
  end

  // Pointer and fill-level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (write_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/xdma_write_resp_tracker.sv
// Tracks AW bursts against B responses for a write master and retires each
// queued request once all of its bursts have been answered.
//
// state  | meaning
// IDLE   | no request at the FIFO head
// ACTIVE | counting B responses for the head request
// RETIRE | head complete: pulse done, pop the head
module xdma_write_resp_tracker
  import xdma_write_resp_tracker_pkg::*;
#(
  parameter int unsigned ReqFifoDepth   = 4,
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [CntWidth-1:0]                   req_bursts_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic                                  aw_valid_i,
  input  logic                                  aw_ready_i,
  output logic                                  aw_allow_o,
  input  logic                                  b_valid_i,
  input  logic [1:0]                            b_resp_i,
  output logic                                  b_ready_o,
  output logic                                  done_o,
  output logic                                  done_err_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  busy_o
);

  localparam int unsigned OutW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned UsageW = ((ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1) + 1;

  state_t              state_q, state_d;
  logic [OutW-1:0]     outstanding_q;
  logic [CntWidth-1:0] b_cnt_q, b_cnt_d;
  logic                err_q, err_d;

  logic                fifo_full, fifo_empty;
  logic [UsageW-1:0]   fifo_usage;
  logic [CntWidth-1:0] head_cnt;
  logic                push, pop;
  logic                aw_hs, b_hs;
  logic                more_after_pop;
  logic                rst_n;

  assign rst_n = ~rst_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (ReqFifoDepth),
    .dtype        (logic [CntWidth-1:0])
  ) i_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_n),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (req_bursts_i),
    .push_i  (push),
    .data_o  (head_cnt),
    .pop_i   (pop)
  );

  assign req_ready_o = ~fifo_full;
  assign push        = req_valid_i & req_ready_o;
  assign pop         = (state_q == ST_RETIRE);

  assign aw_allow_o  = (outstanding_q < OutW'(MaxOutstanding));
  assign b_ready_o   = (state_q == ST_ACTIVE) && (outstanding_q != '0);
  assign aw_hs       = aw_valid_i & aw_ready_i;
  assign b_hs        = b_valid_i & b_ready_o;

  assign done_o        = (state_q == ST_RETIRE);
  assign done_err_o    = (state_q == ST_RETIRE) & err_q;
  assign outstanding_o = outstanding_q;
  assign busy_o        = ~fifo_empty || (outstanding_q != '0);

  // The head is still counted in usage during RETIRE, so more than one entry
  // (or a push landing in the same cycle) means another request follows.
  assign more_after_pop = (fifo_usage != UsageW'(1)) || push;

  // Outstanding burst counter: +1 per AW, -1 per B, unchanged when both.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      unique case ({aw_hs, b_hs})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // FSM next-state, B counting and error accumulation for the head request.
  always_comb begin
    state_d = state_q;
    b_cnt_d = b_cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_ACTIVE;
          b_cnt_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (head_cnt == '0) begin
          state_d = ST_RETIRE;
        end else if (b_hs) begin
          b_cnt_d = b_cnt_q + 1'b1;
          err_d   = err_q | resp_is_err(b_resp_i);
          if ((b_cnt_q + 1'b1) == head_cnt) state_d = ST_RETIRE;
        end
      end
      ST_RETIRE: begin
        state_d = more_after_pop ? ST_ACTIVE : ST_IDLE;
        b_cnt_d = '0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        b_cnt_d = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // FSM and per-request tracking registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      b_cnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_cnt_q <= b_cnt_d;
      err_q   <= err_d;
    end
  end

  // Upstream must gate aw_valid with aw_allow_o; an AW beyond the limit is a protocol error.
  aw_within_limit: assert property (@(posedge clk_i) disable iff (rst_i) aw_hs |-> aw_allow_o);

endmodule
